partoserial: RTL and testbench

Parallel-to-serial transmitter for the PHY TX path. Accepts bytes on an 8-bit valid/ready interface and serialises them MSB-first on a single bit line at clk_8f. It fills every unused byte slot with the idle/comma symbol 8'hBC. After reset it emits a sync preamble of idle symbols, so the far-end serial-to-parallel receiver can lock (the receiver needs ≥5 consecutive 8'hBC) before any data is sent.

---
 rtl/phy_pkg.sv | 14 +
 rtl/piso_shift8.sv | 27 ++
 rtl/partoserial.sv | 97 +++++++++
 tb/tb_partoserial.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY TX definitions: byte geometry, idle/comma symbol and transmitter FSM states.
package phy_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    localparam logic [BYTE_W-1:0] IDLE_SYMBOL = 8'hBC;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_t;

endpackage

// File: rtl/piso_shift8.sv
// 8-bit parallel-load / shift-left register; the MSB drives the serial output.
module piso_shift8
    import phy_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BYTE_W-1:0] din,
    output logic              dout
);

    logic [BYTE_W-1:0] sreg;

    // Load wins over shift; zeros enter from the LSB side.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else begin
            sreg <= {sreg[BYTE_W-2:0], 1'b0};
        end
    end

    assign dout = sreg[BYTE_W-1];

endmodule

// File: rtl/partoserial.sv
// Parallel-to-serial PHY transmitter: sync preamble of idles, then valid/ready bytes MSB-first.
// Optional PARTOSERIAL_STATS_EN adds tx_byte_cnt / idle_cnt statistics outputs.
module partoserial #(
    parameter int unsigned SYNC_SYMBOLS = 8,
    parameter logic [7:0]  IDLE_SYMBOL  = phy_pkg::IDLE_SYMBOL
) (
    input  logic                       clk_8f,
    input  logic                       reset,
    input  logic [phy_pkg::BYTE_W-1:0] data_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic                       data_out,
    output logic                       frame_out,
    output logic                       active_out,
`ifdef PARTOSERIAL_STATS_EN
    output logic [15:0]                tx_byte_cnt,
    output logic [15:0]                idle_cnt,
`endif
    output logic                       err_comma
);

    import phy_pkg::*;

    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(BYTE_W - 1);
    localparam logic [7:0]           SYNC_LAST = 8'(SYNC_SYMBOLS - 1);

    tx_state_t             state;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [7:0]            sync_cnt;
    logic                  load;
    logic                  xfer;
    logic [BYTE_W-1:0]     load_byte;

    assign load      = (bit_cnt == BIT_LAST);
    assign ready_out = (state == ACTIVE) && load;
    assign xfer      = ready_out && valid_in;
    assign load_byte = xfer ? data_in : IDLE_SYMBOL;

    piso_shift8 u_shift (
        .clk   (clk_8f),
        .reset (reset),
        .load  (load),
        .din   (load_byte),
        .dout  (data_out)
    );

    // Slot timing, sync preamble FSM and registered status outputs.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state      <= SYNC;
            bit_cnt    <= BIT_LAST;
            sync_cnt   <= 8'd0;
            frame_out  <= 1'b0;
            active_out <= 1'b0;
            err_comma  <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            frame_out <= load;
            err_comma <= xfer && (data_in == IDLE_SYMBOL);
            case (state)
                SYNC: begin
                    if (load) begin
                        sync_cnt <= sync_cnt + 8'd1;
                        // The final sync load is itself an idle, so the count is exact.
                        if (sync_cnt == SYNC_LAST) begin
                            state      <= ACTIVE;
                            active_out <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    state <= ACTIVE;
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

`ifdef PARTOSERIAL_STATS_EN
    // Byte statistics: only ACTIVE-state loads are counted.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            tx_byte_cnt <= 16'd0;
            idle_cnt    <= 16'd0;
        end else if (ready_out) begin
            if (valid_in) begin
                tx_byte_cnt <= tx_byte_cnt + 16'd1;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_partoserial.sv
// Self-checking bench for partoserial: slot-level reference model plus directed literal pins.
// Build with PARTOSERIAL_STATS_EN to also check the statistics counters.
module tb_partoserial;

    localparam int unsigned S    = 8;
    localparam logic [7:0]  IDLE = 8'hBC;

    logic       clk_8f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       frame_out;
    logic       active_out;
    logic       err_comma;
`ifdef PARTOSERIAL_STATS_EN
    logic [15:0] tx_byte_cnt;
    logic [15:0] idle_cnt;
`endif

    partoserial #(.SYNC_SYMBOLS(S), .IDLE_SYMBOL(IDLE)) dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .frame_out  (frame_out),
        .active_out (active_out),
`ifdef PARTOSERIAL_STATS_EN
        .tx_byte_cnt(tx_byte_cnt),
        .idle_cnt   (idle_cnt),
`endif
        .err_comma  (err_comma)
    );

    initial clk_8f = 1'b0;
    always #5 clk_8f = ~clk_8f;

    int passes = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Serial bits as seen on data_out after each edge, and err_comma pulse count.
    bit dut_bits[$];
    int err_seen = 0;

    function automatic logic [7:0] qbyte(input int slot);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (slot * 8 + i < dut_bits.size()) b[7-i] = dut_bits[slot*8+i];
            else return 8'hxx;
        end
        return b;
    endfunction

    // Reference model: n = edges since reset release; every 8th edge starts a new byte slot.
    initial begin
        int         n = 0;
        bit         q[$];
        logic       r, v;
        logic [7:0] d, b;
        logic       e_data, e_frame, e_active, e_err, e_ready;
        logic [15:0] m_tx = 16'd0, m_idle = 16'd0;
        forever begin
            @(posedge clk_8f);
            r = reset; v = valid_in; d = data_in;
            if (r) begin
                q.delete();
                n = 0;
                e_data = 0; e_frame = 0; e_active = 0; e_err = 0;
                m_tx = 16'd0; m_idle = 16'd0;
            end else begin
                e_frame = (n % 8 == 0);
                e_err   = 0;
                if (n % 8 == 0) begin
                    if (n / 8 < S) b = IDLE;
                    else if (v) begin
                        b = d; m_tx++; e_err = (d == IDLE);
                    end else begin
                        b = IDLE; m_idle++;
                    end
                    for (int i = 7; i >= 0; i--) q.push_back(b[i]);
                end
                e_data   = q.pop_front();
                e_active = (n >= 8 * (S - 1));
                n++;
            end
            e_ready = (n % 8 == 0) && (n / 8 >= S);
            #1;
            dut_bits.push_back(data_out);
            if (err_comma) err_seen++;
            chk("data_out",   data_out,   e_data);
            chk("frame_out",  frame_out,  e_frame);
            chk("active_out", active_out, e_active);
            chk("err_comma",  err_comma,  e_err);
            chk("ready_out",  ready_out,  e_ready);
`ifdef PARTOSERIAL_STATS_EN
            chk("tx_byte_cnt", tx_byte_cnt, m_tx);
            chk("idle_cnt",    idle_cnt,    m_idle);
`endif
        end
    end

    task automatic xfer(input logic [7:0] b, input bit clear_log);
        int k = 0;
        @(negedge clk_8f);
        while (!ready_out && k < 20) begin
            @(negedge clk_8f);
            k++;
        end
        chk("ready_wait", ready_out, 1'b1);
        if (clear_log) dut_bits.delete();
        valid_in = 1'b1;
        data_in  = b;
        @(negedge clk_8f);
        valid_in = 1'b0;
    endtask

    task automatic count_to_ready(input string name);
        int cnt = 0;
        while (!ready_out && cnt < 200) begin
            @(posedge clk_8f);
            #1;
            cnt++;
        end
        chk(name, cnt, 64);
    endtask

    initial begin
        int k;
        reset = 1'b1; valid_in = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge clk_8f);
        dut_bits.delete();
        reset = 1'b0;

        // Preamble: 8 idle slots, ready first high after 64 edges.
        count_to_ready("first_ready_edge");
        chk("preamble_slot0", qbyte(0), 8'hBC);
        chk("preamble_slot7", qbyte(7), 8'hBC);

        // Back-to-back bytes, no idle fill between them.
        xfer(8'h01, 1'b1);
        xfer(8'h80, 1'b0);
        xfer(8'hFF, 1'b0);
        repeat (9) @(negedge clk_8f);
        chk("b2b_byte0", qbyte(0), 8'h01);
        chk("b2b_byte1", qbyte(1), 8'h80);
        chk("b2b_byte2", qbyte(2), 8'hFF);

        // valid only while ready is low: ignored, idles go out.
        k = 0;
        while (!ready_out && k < 20) begin @(negedge clk_8f); k++; end
        dut_bits.delete();
        @(negedge clk_8f);
        valid_in = 1'b1; data_in = 8'h3C;
        k = 0;
        while (!ready_out && k < 20) begin @(negedge clk_8f); k++; end
        valid_in = 1'b0;
        repeat (9) @(negedge clk_8f);
        chk("pulse_slot0_idle", qbyte(0), 8'hBC);
        chk("pulse_slot1_idle", qbyte(1), 8'hBC);
        xfer(8'h3C, 1'b1);
        repeat (9) @(negedge clk_8f);
        chk("held_3c", qbyte(0), 8'h3C);

        // Comma as data: sent unchanged, one err pulse.
        err_seen = 0;
        xfer(8'hBC, 1'b1);
        repeat (10) @(negedge clk_8f);
        chk("comma_byte", qbyte(0), 8'hBC);
        chk("comma_err_pulses", err_seen, 1);

        // Randomised traffic against the model.
        repeat (800) begin
            @(negedge clk_8f);
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = ($urandom_range(0, 4) == 0) ? IDLE : 8'($urandom);
        end
        valid_in = 1'b0;

        // Reset mid-byte aborts and restarts the full preamble.
        xfer(8'hF0, 1'b1);
        repeat (2) @(negedge clk_8f);
        reset = 1'b1;
        @(negedge clk_8f);
        chk("reset_data_out", data_out, 1'b0);
        chk("reset_active",   active_out, 1'b0);
`ifdef PARTOSERIAL_STATS_EN
        chk("reset_tx_cnt", tx_byte_cnt, 16'd0);
`endif
        dut_bits.delete();
        reset = 1'b0;
        count_to_ready("ready_after_reset");
        chk("re_preamble_slot0", qbyte(0), 8'hBC);
        chk("re_preamble_slot7", qbyte(7), 8'hBC);
        xfer(8'h5A, 1'b1);
        repeat (9) @(negedge clk_8f);
        chk("post_reset_byte", qbyte(0), 8'h5A);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
